// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_sub1.sv
// -----------------------------------------------------------------------------
// sub1
// Purely combinational 1-bit full subtractor: {Bout, d} = A - B - Bin.
//
// Ports:
//   A    : minuend bit
//   B    : subtrahend bit
//   Bin  : borrow in from the previous (less significant) bit
//   d    : difference bit
//   Bout : borrow out to the next (more significant) bit
// -----------------------------------------------------------------------------
module sub1 (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic d,
  output logic Bout
);

  assign d    = A ^ B ^ Bin;
  // Borrow out when the minuend bit cannot cover B, or when A == B and a
  // borrow is already pending from below.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor computing A - B one bit per cycle,
// LSB first, using one sub1 cell and a single borrow flip-flop.
//
// Optional feature macro: SERIAL_SUBTRACTOR_CMP_EN adds the Zero and Less
// compare outputs.
//
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high reset
//   start    : request, sampled only while idle
//   A, B     : minuend / subtrahend, captured on the accepting edge
//   busy     : high while the operation is in progress and in its done cycle
//   done     : one-cycle pulse, results valid from this cycle on
//   diff     : A - B modulo 2^WIDTH
//   Borrow   : 1 iff unsigned A < B
//   Overflow : signed overflow of A - B
//   Zero     : (CMP_EN only) diff == 0
//   Less     : (CMP_EN only) signed A < B
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Borrow,
  output logic             Overflow
`ifdef SERIAL_SUBTRACTOR_CMP_EN
  ,
  output logic             Zero,
  output logic             Less
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             cell_d;
  logic             cell_bout;
  logic             ovf_next;

  sub1 u_cell (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Bin  (borrow),
    .d    (cell_d),
    .Bout (cell_bout)
  );

  // Result register shifts right with the new difference bit entering at the
  // MSB; after WIDTH steps it holds the full difference in natural order.
  // NOTE: every signal driven here is assigned unconditionally, so no latch
  // can be inferred.
  always_comb begin
    res_next = (res_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
    // Operands of opposite sign whose difference flips away from A's sign.
    ovf_next = (a_msb ^ b_msb) & (cell_d ^ a_msb);
  end

  // NOTE: all state uses non-blocking assignments so each register samples
  // the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and overrides every other action, including
    // an operation in flight; all registers are plain flops and are cleared.
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      Borrow   <= 1'b0;
      Overflow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
      Zero     <= 1'b0;
      Less     <= 1'b0;
`endif
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          borrow <= cell_bout;
          if (cnt == LAST) begin
            // Final (MSB) step: publish results; the counter is left at its
            // last value rather than wrapping.
            diff     <= res_next;
            Borrow   <= cell_bout;
            Overflow <= ovf_next;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
            Zero     <= (res_next == '0);
            Less     <= cell_d ^ ovf_next;
`endif
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor at WIDTH=8. A cycle-level
// behavioural model (operation timeline + plain integer arithmetic) predicts
// every output on every cycle; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         Borrow;
  logic         Overflow;
`ifdef SERIAL_SUBTRACTOR_CMP_EN
  logic         Zero;
  logic         Less;
`endif

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .Borrow   (Borrow),
    .Overflow (Overflow)
`ifdef SERIAL_SUBTRACTOR_CMP_EN
    ,
    .Zero     (Zero),
    .Less     (Less)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: an accepted request keeps the block busy for W+1
  // cycles; results appear (with done) in the last of those cycles.
  // ---------------------------------------------------------------------------
  int           left = 0;
  bit           model_live = 0;
  logic [W-1:0] exp_diff = '0;
  logic         exp_borrow = 0, exp_ovf = 0, exp_zero = 0, exp_less = 0;
  logic [W-1:0] p_diff;
  logic         p_borrow, p_ovf, p_zero, p_less;

  always @(posedge clk) begin
    if (reset) begin
      left       = 0;
      exp_diff   = '0;
      exp_borrow = 0;
      exp_ovf    = 0;
      exp_zero   = 0;
      exp_less   = 0;
    end else if (left == 0) begin
      if (start === 1'b1) begin
        int ua, ub, sa, sb, dv;
        ua = int'(A);
        ub = int'(B);
        sa = int'($signed(A));
        sb = int'($signed(B));
        dv = sa - sb;
        p_diff   = W'(ua - ub);
        p_borrow = (ua < ub);
        p_ovf    = (dv < -(1 << (W - 1))) || (dv > (1 << (W - 1)) - 1);
        p_zero   = (ua == ub);
        p_less   = (sa < sb);
        left     = W + 1;
      end
    end else begin
      left--;
      if (left == 1) begin
        exp_diff   = p_diff;
        exp_borrow = p_borrow;
        exp_ovf    = p_ovf;
        exp_zero   = p_zero;
        exp_less   = p_less;
      end
    end
    model_live = 1;
  end

  // Compare process: every output, every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("m_busy",     {31'd0, busy},     {31'd0, (left > 0)});
      check("m_done",     {31'd0, done},     {31'd0, (left == 1)});
      check("m_diff",     {24'd0, diff},     {24'd0, exp_diff});
      check("m_borrow",   {31'd0, Borrow},   {31'd0, exp_borrow});
      check("m_overflow", {31'd0, Overflow}, {31'd0, exp_ovf});
`ifdef SERIAL_SUBTRACTOR_CMP_EN
      check("m_zero",     {31'd0, Zero},     {31'd0, exp_zero});
      check("m_less",     {31'd0, Less},     {31'd0, exp_less});
`endif
    end
  end

  // Issue one request from a falling edge while idle; returns at the falling
  // edge where done is seen, with lat = edges from acceptance to done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    start = 1'b1;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] d, input logic bo, input logic ov);
    check({tag, "_diff"},     {24'd0, diff},     {24'd0, d});
    check({tag, "_borrow"},   {31'd0, Borrow},   {31'd0, bo});
    check({tag, "_overflow"}, {31'd0, Overflow}, {31'd0, ov});
  endtask

  initial begin
    int lat;
    int first_done, second_done, done_hi;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check_res("rst", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // 5 - 3: done rises after edge W counted from the accepting edge.
    do_op(8'h05, 8'h03, lat);
    check("latency", lat, W);
    check_res("s1", 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    check("s1_done_pulse", {31'd0, done}, 32'd0);
    check("s1_busy_clear", {31'd0, busy}, 32'd0);

    // 3 - 5
    do_op(8'h03, 8'h05, lat);
    check_res("s2", 8'hFE, 1'b1, 1'b0);
`ifdef SERIAL_SUBTRACTOR_CMP_EN
    check("s2_less", {31'd0, Less}, 32'd1);
    check("s2_zero", {31'd0, Zero}, 32'd0);
`endif
    @(negedge clk);

    // Signed overflow in both directions.
    do_op(8'h80, 8'h01, lat);
    check_res("s3a", 8'h7F, 1'b0, 1'b1);
    @(negedge clk);
    do_op(8'h7F, 8'hFF, lat);
    check_res("s3b", 8'h80, 1'b1, 1'b1);
    @(negedge clk);

    // Equal operands.
    do_op(8'h5A, 8'h5A, lat);
    check_res("s4", 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_CMP_EN
    check("s4_zero", {31'd0, Zero}, 32'd1);
    check("s4_less", {31'd0, Less}, 32'd0);
`endif
    @(negedge clk);

    // start pulsed during RUN is ignored and not queued.
    start = 1'b1;
    A     = 8'h10;
    B     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    A     = 8'hFF;
    B     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("s5_done_seen", {31'd0, done}, 32'd1);
    check_res("s5", 8'h0F, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("s5_no_queue", {31'd0, busy}, 32'd0);

    // Reset mid-RUN aborts without a done pulse.
    start = 1'b1;
    A     = 8'h33;
    B     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("s6_busy", {31'd0, busy}, 32'd0);
    check("s6_done", {31'd0, done}, 32'd0);
    check_res("s6", 8'h00, 1'b0, 1'b0);
    done_hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) done_hi++;
    end
    check("s6_no_done", done_hi, 0);
    do_op(8'h33, 8'h11, lat);
    check_res("s6_fresh", 8'h22, 1'b0, 1'b0);
    @(negedge clk);

    // start held high: re-accepted on the first idle edge, spacing W+2.
    start       = 1'b1;
    A           = 8'h20;
    B           = 8'h08;
    first_done  = -1;
    second_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    start = 1'b0;
    check("held_spacing", second_done - first_done, W + 2);
    check_res("held", 8'h18, 1'b0, 1'b0);
    repeat (W + 4) @(negedge clk);

    // Randomized traffic with occasional corner operands and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] corner [4];
      corner[0] = 8'h00;
      corner[1] = 8'h7F;
      corner[2] = 8'h80;
      corner[3] = 8'hFF;
      start = ($urandom_range(0, 3) == 0);
      A     = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      B     = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
